// File: rtl/lcd_controller_pkg.sv
// Shared definitions for the HD44780 4-bit LCD driver: state encoding,
// command codes, wake-up nibble table, default timings and small helpers.
package lcd_defs;

    localparam int TIMER_WIDTH = 20;

    localparam int unsigned T_POWERUP_DEFAULT    = 750000;
    localparam int unsigned T_WAKE1_DEFAULT      = 205000;
    localparam int unsigned T_WAKE2_DEFAULT      = 5000;
    localparam int unsigned T_SETUP_DEFAULT      = 2;
    localparam int unsigned T_E_HIGH_DEFAULT     = 12;
    localparam int unsigned T_NIBBLE_GAP_DEFAULT = 50;
    localparam int unsigned T_CMD_DEFAULT        = 2000;
    localparam int unsigned T_CLEAR_DEFAULT      = 82000;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Wake-up nibbles for steps 0..3 (3,3,3,2), step 0 in the low nibble.
    localparam logic [15:0] WAKE_NIBBLES = 16'h2333;

    localparam logic [3:0] S_PWR_WAIT = 4'd0;
    localparam logic [3:0] S_WK_SETUP = 4'd1;
    localparam logic [3:0] S_WK_E     = 4'd2;
    localparam logic [3:0] S_WK_WAIT  = 4'd3;
    localparam logic [3:0] S_IDLE     = 4'd4;
    localparam logic [3:0] S_HI_SETUP = 4'd5;
    localparam logic [3:0] S_HI_E     = 4'd6;
    localparam logic [3:0] S_HI_GAP   = 4'd7;
    localparam logic [3:0] S_LO_SETUP = 4'd8;
    localparam logic [3:0] S_LO_E     = 4'd9;
    localparam logic [3:0] S_LO_WAIT  = 4'd10;

    typedef enum logic [3:0] {
        PWR_WAIT = S_PWR_WAIT,
        WK_SETUP = S_WK_SETUP,
        WK_E     = S_WK_E,
        WK_WAIT  = S_WK_WAIT,
        IDLE     = S_IDLE,
        HI_SETUP = S_HI_SETUP,
        HI_E     = S_HI_E,
        HI_GAP   = S_HI_GAP,
        LO_SETUP = S_LO_SETUP,
        LO_E     = S_LO_E,
        LO_WAIT  = S_LO_WAIT
    } state_t;

    function automatic logic [3:0] wake_nibble(input logic [1:0] step);
        return WAKE_NIBBLES[{step, 2'b00} +: 4];
    endfunction

    // A state lasting n cycles loads n-1 so that it exits on the count of zero.
    function automatic logic [TIMER_WIDTH-1:0] to_count(input int unsigned cycles);
        return TIMER_WIDTH'(cycles - 1);
    endfunction

    function automatic logic is_slow_cmd(input logic [7:0] value, input logic rs);
        return !rs && (value == LCD_CMD_CLEAR || value == LCD_CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_controller_if.sv
// CPU-side write handshake and board LCD pins of the LCD driver.
interface lcd_controller_if;

    logic       write_strobe;
    logic [7:0] data;
    logic       rs;
    logic       ready;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_data;
    logic       lcd_strataflash_control;

    modport master (
        output write_strobe, data, rs,
        input  ready, lcd_e, lcd_rs, lcd_rw, lcd_data, lcd_strataflash_control
    );

    modport slave (
        input  write_strobe, data, rs,
        output ready, lcd_e, lcd_rs, lcd_rw, lcd_data, lcd_strataflash_control
    );

endinterface

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by all timed states of the LCD driver;
// done is high whenever the count sits at zero.
module lcd_delay_timer
    import lcd_defs::*;
(
    input  logic                   clk,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] value,
    input  logic                   count_en,
    output logic                   done
);

    logic [TIMER_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= value;
        end else if (count_en && count != '0) begin
            count <= count - TIMER_WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lcd_controller.sv
// HD44780 4-bit LCD driver: autonomous power-up wake-up sequence, then one
// byte per accepted strobe sent as two timed nibble transfers.
module lcd_controller
    import lcd_defs::*;
#(
    parameter int unsigned T_POWERUP    = T_POWERUP_DEFAULT,
    parameter int unsigned T_WAKE1      = T_WAKE1_DEFAULT,
    parameter int unsigned T_WAKE2      = T_WAKE2_DEFAULT,
    parameter int unsigned T_SETUP      = T_SETUP_DEFAULT,
    parameter int unsigned T_E_HIGH     = T_E_HIGH_DEFAULT,
    parameter int unsigned T_NIBBLE_GAP = T_NIBBLE_GAP_DEFAULT,
    parameter int unsigned T_CMD        = T_CMD_DEFAULT,
    parameter int unsigned T_CLEAR      = T_CLEAR_DEFAULT
)
(
    input  logic clk,
    input  logic rst,
    lcd_controller_if.slave bus
);

    state_t                 state;
    logic [1:0]             step;
    logic [7:0]             latched_data;
    logic                   ready;
    logic                   lcd_e;
    logic                   lcd_rs;
    logic [3:0]             lcd_data;
    logic                   accept;
    logic                   load;
    logic [TIMER_WIDTH-1:0] load_value;
    logic                   done;

    function automatic logic [TIMER_WIDTH-1:0] wake_wait(input logic [1:0] s);
        case (s)
            2'd0:    return to_count(T_WAKE1);
            2'd1:    return to_count(T_WAKE2);
            default: return to_count(T_CMD);
        endcase
    endfunction

    assign accept = (state == IDLE) && ready && bus.write_strobe;

    // Reload the shared timer with the length of the state being entered.
    always_comb begin
        load       = 1'b0;
        load_value = '0;
        if (rst) begin
            load       = 1'b1;
            load_value = to_count(T_POWERUP);
        end else if (accept) begin
            load       = 1'b1;
            load_value = to_count(T_SETUP);
        end else if (done) begin
            case (state)
                PWR_WAIT, HI_GAP: begin
                    load       = 1'b1;
                    load_value = to_count(T_SETUP);
                end
                WK_SETUP, HI_SETUP, LO_SETUP: begin
                    load       = 1'b1;
                    load_value = to_count(T_E_HIGH);
                end
                WK_E: begin
                    load       = 1'b1;
                    load_value = wake_wait(step);
                end
                WK_WAIT: begin
                    load       = (step != 2'd3);
                    load_value = to_count(T_SETUP);
                end
                HI_E: begin
                    load       = 1'b1;
                    load_value = to_count(T_NIBBLE_GAP);
                end
                LO_E: begin
                    load       = 1'b1;
                    load_value = is_slow_cmd(latched_data, lcd_rs) ? to_count(T_CLEAR)
                                                                   : to_count(T_CMD);
                end
                default: begin
                    load       = 1'b0;
                    load_value = '0;
                end
            endcase
        end
    end

    lcd_delay_timer timer (
        .clk      (clk),
        .load     (load),
        .value    (load_value),
        .count_en (state != IDLE),
        .done     (done)
    );

    // Sequencer; pins and ready are registered so they change only on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PWR_WAIT;
            step         <= 2'd0;
            latched_data <= 8'h00;
            ready        <= 1'b0;
            lcd_e        <= 1'b0;
            lcd_rs       <= 1'b0;
            lcd_data     <= 4'h0;
        end else begin
            case (state)
                PWR_WAIT: if (done) begin
                    state    <= WK_SETUP;
                    lcd_rs   <= 1'b0;
                    lcd_data <= wake_nibble(step);
                end
                WK_SETUP: if (done) begin
                    state <= WK_E;
                    lcd_e <= 1'b1;
                end
                WK_E: if (done) begin
                    state <= WK_WAIT;
                    lcd_e <= 1'b0;
                end
                WK_WAIT: if (done) begin
                    if (step == 2'd3) begin
                        state <= IDLE;
                    end else begin
                        state    <= WK_SETUP;
                        step     <= step + 2'd1;
                        lcd_data <= wake_nibble(step + 2'd1);
                    end
                end
                IDLE: begin
                    if (accept) begin
                        state        <= HI_SETUP;
                        latched_data <= bus.data;
                        lcd_rs       <= bus.rs;
                        lcd_data     <= bus.data[7:4];
                        ready        <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                HI_SETUP: if (done) begin
                    state <= HI_E;
                    lcd_e <= 1'b1;
                end
                HI_E: if (done) begin
                    state <= HI_GAP;
                    lcd_e <= 1'b0;
                end
                HI_GAP: if (done) begin
                    state    <= LO_SETUP;
                    lcd_data <= latched_data[3:0];
                end
                LO_SETUP: if (done) begin
                    state <= LO_E;
                    lcd_e <= 1'b1;
                end
                LO_E: if (done) begin
                    state <= LO_WAIT;
                    lcd_e <= 1'b0;
                end
                LO_WAIT: if (done) begin
                    state <= IDLE;
                end
                default: begin
                    state <= PWR_WAIT;
                end
            endcase
        end
    end

    assign bus.ready                   = ready;
    assign bus.lcd_e                   = lcd_e;
    assign bus.lcd_rs                  = lcd_rs;
    assign bus.lcd_data                = lcd_data;
    assign bus.lcd_rw                  = 1'b0;
    assign bus.lcd_strataflash_control = 1'b1;

endmodule

// File: tb/tb_lcd_controller.sv
// Randomised bench for lcd_controller with shortened timings; E pulses are
// captured by a pin monitor and compared against a cycle-count model.
module tb_lcd_controller;

    localparam int TP  = 20;
    localparam int TW1 = 10;
    localparam int TW2 = 5;
    localparam int TS  = 2;
    localparam int TE  = 12;
    localparam int TG  = 4;
    localparam int TC  = 8;
    localparam int TCL = 30;
    localparam int BOUND = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    lcd_controller_if bus();

    lcd_controller #(
        .T_POWERUP(TP), .T_WAKE1(TW1), .T_WAKE2(TW2), .T_SETUP(TS),
        .T_E_HIGH(TE), .T_NIBBLE_GAP(TG), .T_CMD(TC), .T_CLEAR(TCL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nibble;
        logic       rs;
        int         width;
        bit         stable;
    } pulse_t;

    pulse_t pulses[$];
    pulse_t cur;
    logic   prev_e = 1'b0;

    // Pin monitor: one record per completed E pulse, flagging data/RS movement while E is high.
    always @(negedge clk) begin
        if (bus.lcd_e === 1'b1) begin
            if (prev_e !== 1'b1) begin
                cur.nibble = bus.lcd_data;
                cur.rs     = bus.lcd_rs;
                cur.width  = 1;
                cur.stable = 1'b1;
            end else begin
                cur.width = cur.width + 1;
                if (bus.lcd_data !== cur.nibble || bus.lcd_rs !== cur.rs) cur.stable = 1'b0;
            end
        end else if (prev_e === 1'b1) begin
            pulses.push_back(cur);
        end
        prev_e = bus.lcd_e;
    end

    // Reference model
    function automatic int expected_busy(input logic [7:0] b, input logic r);
        int post;
        post = (r == 1'b0 && (b == 8'h01 || b == 8'h02)) ? TCL : TC;
        return 2 * TS + 2 * TE + TG + post + 1;
    endfunction

    function automatic int expected_wake_rise();
        int waits[4];
        int total;
        waits = '{TW1, TW2, TC, TC};
        total = TP;
        for (int k = 0; k < 4; k++) total += TS + TE + waits[k];
        return total + 1;
    endfunction

    // Measures from the first post-reset cycle until ready rises.
    task automatic run_wakeup(output int rise, output bit quiet);
        rise  = -1;
        quiet = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            if (i > 0) @(negedge clk);
            if (i < TP && (bus.lcd_e !== 1'b0 || bus.lcd_data !== 4'h0 ||
                           bus.lcd_rs !== 1'b0 || bus.ready !== 1'b0)) quiet = 1'b0;
            if (bus.ready === 1'b1) begin
                rise = i;
                break;
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        for (int i = 0; i < BOUND && bus.ready !== 1'b1; i++) @(negedge clk);
        ok = (bus.ready === 1'b1);
    endtask

    // Strobes one byte, scrambles the inputs afterwards, counts ready-low cycles.
    task automatic applyStimulus(input logic [7:0] b, input logic r, output int busy, output bit ok);
        busy = 0;
        wait_ready(ok);
        if (!ok) return;
        bus.write_strobe = 1'b1;
        bus.data         = b;
        bus.rs           = r;
        @(negedge clk);
        bus.write_strobe = 1'b0;
        bus.data         = 8'($urandom);
        bus.rs           = 1'($urandom);
        while (bus.ready !== 1'b1 && busy < BOUND) begin
            busy++;
            @(negedge clk);
        end
        ok = (bus.ready === 1'b1);
    endtask

    task automatic test_reset();
        int rise;
        bit quiet;
        logic [3:0] exp_nib[4];
        exp_nib = '{4'h3, 4'h3, 4'h3, 4'h2};
        rst = 1'b1;
        bus.write_strobe = 1'b0;
        bus.data = 8'h00;
        bus.rs = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compared++; if (bus.ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got %b want 0", bus.ready); end
        compared++; if (bus.lcd_e !== 1'b0) begin mismatched++; $display("FAIL reset_e got %b want 0", bus.lcd_e); end
        compared++; if (bus.lcd_rs !== 1'b0) begin mismatched++; $display("FAIL reset_rs got %b want 0", bus.lcd_rs); end
        compared++; if (bus.lcd_data !== 4'h0) begin mismatched++; $display("FAIL reset_data got %h want 0", bus.lcd_data); end
        compared++; if (bus.lcd_rw !== 1'b0) begin mismatched++; $display("FAIL reset_rw got %b want 0", bus.lcd_rw); end
        compared++; if (bus.lcd_strataflash_control !== 1'b1) begin mismatched++; $display("FAIL reset_flash got %b want 1", bus.lcd_strataflash_control); end
        rst = 1'b0;
        pulses.delete();
        run_wakeup(rise, quiet);
        compared++; if (quiet !== 1'b1) begin mismatched++; $display("FAIL powerup_quiet got %b want 1", quiet); end
        compared++; if (rise != expected_wake_rise()) begin mismatched++; $display("FAIL wake_ready_rise got %0d want %0d", rise, expected_wake_rise()); end
        compared++; if (pulses.size() != 4) begin mismatched++; $display("FAIL wake_pulse_count got %0d want 4", pulses.size()); end
        for (int k = 0; k < 4 && k < pulses.size(); k++) begin
            compared++;
            if (pulses[k].nibble !== exp_nib[k] || pulses[k].rs !== 1'b0 ||
                pulses[k].width != TE || !pulses[k].stable) begin
                mismatched++;
                $display("FAIL wake_pulse%0d got nib=%h rs=%b w=%0d st=%b want nib=%h rs=0 w=%0d st=1",
                         k, pulses[k].nibble, pulses[k].rs, pulses[k].width, pulses[k].stable, exp_nib[k], TE);
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] b, input logic r, input int busy, input bit ok);
        logic [3:0] exp_nib[2];
        exp_nib = '{b[7:4], b[3:0]};
        compared++; if (!ok) begin mismatched++; $display("FAIL %s_timeout got busy=%0d want ready within %0d", name, busy, BOUND); end
        compared++; if (busy != expected_busy(b, r)) begin mismatched++; $display("FAIL %s_busy byte=%h rs=%b got %0d want %0d", name, b, r, busy, expected_busy(b, r)); end
        compared++; if (pulses.size() != 2) begin mismatched++; $display("FAIL %s_pulse_count got %0d want 2", name, pulses.size()); end
        for (int k = 0; k < 2 && k < pulses.size(); k++) begin
            compared++;
            if (pulses[k].nibble !== exp_nib[k] || pulses[k].rs !== r ||
                pulses[k].width != TE || !pulses[k].stable) begin
                mismatched++;
                $display("FAIL %s_nibble%0d got nib=%h rs=%b w=%0d st=%b want nib=%h rs=%b w=%0d st=1",
                         name, k, pulses[k].nibble, pulses[k].rs, pulses[k].width, pulses[k].stable, exp_nib[k], r, TE);
            end
        end
    endtask

    task automatic test_data_write();
        int busy;
        bit ok;
        pulses.delete();
        applyStimulus(8'h41, 1'b1, busy, ok);
        checkOutput("data41", 8'h41, 1'b1, busy, ok);
    endtask

    task automatic test_clear();
        int busy;
        bit ok;
        pulses.delete();
        applyStimulus(8'h01, 1'b0, busy, ok);
        checkOutput("clear", 8'h01, 1'b0, busy, ok);
        pulses.delete();
        applyStimulus(8'h02, 1'b0, busy, ok);
        checkOutput("home", 8'h02, 1'b0, busy, ok);
        pulses.delete();
        applyStimulus(8'h01, 1'b1, busy, ok);
        checkOutput("data01", 8'h01, 1'b1, busy, ok);
    endtask

    task automatic test_random_writes();
        int busy;
        bit ok;
        logic [7:0] b;
        logic r;
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 2));
            r = 1'($urandom);
            pulses.delete();
            applyStimulus(b, r, busy, ok);
            checkOutput("random", b, r, busy, ok);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int busy;
        bit ok;
        wait_ready(ok);
        pulses.delete();
        bus.write_strobe = 1'b1;
        bus.data = 8'h55;
        bus.rs = 1'b0;
        @(negedge clk);
        bus.data = 8'hAA;
        n = 0;
        while (bus.ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        bus.write_strobe = 1'b0;
        compared++; if (pulses.size() != 2 || pulses[0].nibble !== 4'h5 || pulses[1].nibble !== 4'h5) begin
            mismatched++;
            $display("FAIL busy_strobe_ignored got count=%0d first=%h last=%h want count=2 nibbles 5,5",
                     pulses.size(), pulses.size() > 0 ? pulses[0].nibble : 4'hx,
                     pulses.size() > 0 ? pulses[pulses.size()-1].nibble : 4'hx);
        end
        @(negedge clk);
        compared++; if (bus.ready !== 1'b1) begin mismatched++; $display("FAIL busy_no_queue got ready=%b want 1", bus.ready); end
        pulses.delete();
        applyStimulus(8'hAA, 1'b0, busy, ok);
        checkOutput("after_busy", 8'hAA, 1'b0, busy, ok);
    endtask

    task automatic test_held_strobe();
        int first_rise;
        int pulses_at_rise;
        int accepts;
        bit ok;
        accepts = 0;
        for (int t = 0; t < 100; t += expected_busy(8'h30, 1'b0) + 1) accepts++;
        wait_ready(ok);
        pulses.delete();
        first_rise = -1;
        pulses_at_rise = -1;
        bus.write_strobe = 1'b1;
        bus.data = 8'h30;
        bus.rs = 1'b0;
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            if (first_rise < 0 && bus.ready === 1'b1) begin
                first_rise = i;
                pulses_at_rise = pulses.size();
            end
        end
        @(negedge clk);
        bus.write_strobe = 1'b0;
        wait_ready(ok);
        compared++; if (first_rise != expected_busy(8'h30, 1'b0) + 1) begin mismatched++; $display("FAIL held_first_rise got %0d want %0d", first_rise, expected_busy(8'h30, 1'b0) + 1); end
        compared++; if (pulses_at_rise != 2) begin mismatched++; $display("FAIL held_one_byte got %0d pulses want 2", pulses_at_rise); end
        compared++; if (!ok || pulses.size() != 2 * accepts) begin mismatched++; $display("FAIL held_total got %0d pulses ok=%b want %0d", pulses.size(), ok, 2 * accepts); end
        for (int k = 0; k < pulses.size(); k++) begin
            compared++;
            if (pulses[k].nibble !== ((k % 2 == 0) ? 4'h3 : 4'h0) || pulses[k].width != TE) begin
                mismatched++;
                $display("FAIL held_nibble%0d got nib=%h w=%0d want nib=%h w=%0d", k, pulses[k].nibble, pulses[k].width, (k % 2 == 0) ? 4'h3 : 4'h0, TE);
            end
        end
    endtask

    task automatic test_reset_mid();
        int rise;
        int n;
        bit quiet;
        bit ok;
        wait_ready(ok);
        bus.write_strobe = 1'b1;
        bus.data = 8'($urandom);
        bus.rs = 1'($urandom);
        @(negedge clk);
        bus.write_strobe = 1'b0;
        n = 0;
        while (bus.lcd_e !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        compared++; if (bus.lcd_e !== 1'b1) begin mismatched++; $display("FAIL mid_reach_hi_e got e=%b want 1", bus.lcd_e); end
        repeat ($urandom_range(0, TE - 3)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compared++; if (bus.lcd_e !== 1'b0 || bus.ready !== 1'b0) begin mismatched++; $display("FAIL mid_reset_abort got e=%b ready=%b want 0 0", bus.lcd_e, bus.ready); end
        @(negedge clk);
        rst = 1'b0;
        pulses.delete();
        run_wakeup(rise, quiet);
        compared++; if (quiet !== 1'b1) begin mismatched++; $display("FAIL mid_powerup_quiet got %b want 1", quiet); end
        compared++; if (rise != expected_wake_rise()) begin mismatched++; $display("FAIL mid_wake_rise got %0d want %0d", rise, expected_wake_rise()); end
        compared++; if (pulses.size() != 4 || pulses[0].nibble !== 4'h3 || pulses[3].nibble !== 4'h2) begin
            mismatched++;
            $display("FAIL mid_wake_pulses got count=%0d want 4 pulses 3,3,3,2", pulses.size());
        end
    endtask

    initial begin
        $display("[TB] lcd_controller bench start");
        test_reset();
        test_data_write();
        test_clear();
        test_back_to_back();
        test_held_strobe();
        test_random_writes();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion want finish before 2000000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lcd_controller.md
Name: lcd_controller

Overview:
- HD44780-compatible 4-bit character LCD driver that services the CPU's LCD instruction.
- Accepts one byte per write strobe and runs the power-up wake-up sequence autonomously.
- Splits each byte into two timed nibble transfers and reports completion on oReady, which is the CPU's sync flag polled by BRANCH_IF_NSYNC.
- Sits between the CPU core and the board LCD pins.

Parameters:
T_POWERUP, 750000, cycles waited after reset before the first wake-up nibble (15 ms at 50 MHz)
T_WAKE1, 205000, wait after the first 0x3 nibble (4.1 ms)
T_WAKE2, 5000, wait after the second 0x3 nibble (100 us)
T_SETUP, 2, cycles data/RS are stable with E low before E rises
T_E_HIGH, 12, E pulse width in cycles
T_NIBBLE_GAP, 50, wait between the high and low nibble (1 us)
T_CMD, 2000, post-byte wait and wake-up waits 3 and 4 (40 us)
T_CLEAR, 82000, post-byte wait for clear/home commands (1.64 ms)

Ports:
Clock  input  1  system clock, 50 MHz
Reset  input  1  synchronous, active-high
iWriteStrobe  input  1  single-cycle write request
iData  input  8  byte to send
iRS  input  1  register select: 0 = command, 1 = data
oReady  output  1  high when idle and able to accept a strobe
oLCD_E  output  1  LCD enable
oLCD_RS  output  1  LCD register select
oLCD_RW  output  1  tied to 0 (write only)
oLCD_Data  output  4  LCD DB[7:4]
oLCD_StrataFlashControl  output  1  tied to 1 (disables shared flash)

Behaviour:
- Clocking/reset: single clock Clock; Reset is synchronous and active-high.
- Outputs while Reset is high and on the first cycle after: oReady=0, oLCD_E=0, oLCD_RS=0, oLCD_Data=0, oLCD_RW=0, oLCD_StrataFlashControl=1.
- Reset mid-operation: Reset asserted in any state aborts immediately and restarts from PWR_WAIT. E drops the cycle after Reset is sampled.
- Timed states: every timed state lasts exactly its parameter count in cycles. A shared down-counter is loaded on state entry, and the state exits when the counter reaches 0.
- States and transitions:
  - PWR_WAIT (T_POWERUP) -> WK_SETUP
  - WK_SETUP (T_SETUP) -> WK_E (T_E_HIGH, oLCD_E=1) -> WK_WAIT
  - WK_WAIT advances step 0..3 with nibbles 3,3,3,2 and waits T_WAKE1, T_WAKE2, T_CMD, T_CMD. After step 3 -> IDLE.
  - Wake-up nibbles use RS=0.
  - IDLE: oReady=1. If iWriteStrobe is high, latch iData and iRS -> HI_SETUP.
  - HI_SETUP (T_SETUP, oLCD_Data=byte[7:4]) -> HI_E (T_E_HIGH) -> HI_GAP (T_NIBBLE_GAP) -> LO_SETUP (byte[3:0]) -> LO_E -> LO_WAIT -> IDLE.
  - LO_WAIT lasts T_CLEAR when latched RS=0 and byte is 0x01 or 0x02. Otherwise it lasts T_CMD.
- Strobe acceptance: a strobe is accepted only in a cycle where oReady=1. oReady drops the next cycle.
  - Strobes while oReady=0 are ignored; no queueing.
  - Strobe held high for several cycles yields exactly one write, because oReady falls after the first.
  - Strobe in the same cycle that IDLE is entered (oReady still 0) is ignored.
- Output stability: oLCD_RS and oLCD_Data hold the latched values from setup entry through the E-low cycle after the pulse. iData changes after acceptance have no effect.
- Latency: acceptance to oReady high = 2*T_SETUP + 2*T_E_HIGH + T_NIBBLE_GAP + post-byte wait, plus 1 cycle. With defaults: 2079 cycles, or 82079 cycles for clear/home.
- Counter: 20 bits, wide enough for T_POWERUP. Parameters are restricted to 1..2^20-1.

Decomposition:
- Package lcd_defs holds:
  - state encoding (4-bit localparams)
  - command codes LCD_CMD_CLEAR=8'h01 and LCD_CMD_HOME=8'h02
  - wake-up nibble table
  - default timing constants
- Sub-module lcd_delay_timer: loadable 20-bit down-counter with load, count and done. The FSM lives in lcd_controller.

Test Plan:
The bench overrides timings to T_POWERUP=20, T_WAKE1=10, T_WAKE2=5, T_CMD=8, T_CLEAR=30, T_NIBBLE_GAP=4; T_SETUP=2 and T_E_HIGH=12 stay at default.
- Reset then idle: Reset 1 cycle -> exactly four E pulses with data 3,3,3,2, each 12 cycles wide. oReady rises only after the fourth wait; outputs stay at reset values during PWR_WAIT.
- Data write: strobe iData=8'h41, iRS=1 -> nibbles 4 then 1 with RS=1 and two 12-cycle E pulses. oReady low for exactly 2*2+2*12+4+8+1 = 41 cycles.
- Clear command: iData=8'h01, iRS=0 -> LO_WAIT takes 30 cycles; oReady returns 63 cycles after acceptance. iData=8'h01 with iRS=1 uses T_CMD.
- Busy strobes: strobe 8'h55, then strobe 8'hAA every cycle while busy -> only 0x5,0x5 nibbles appear; a strobe after oReady=1 sends 0xA,0xA.
- Reset mid-transfer: assert Reset during HI_E -> E=0 next cycle, oReady=0, and the full wake-up sequence repeats.
- Held strobe: iWriteStrobe high for 100 cycles with iData=8'h30 -> exactly one byte transferred before oReady returns; a second byte starts only once oReady=1.
